// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Bit-counter width: $clog2(n), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor.
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int unsigned N = DEF_WIDTH
);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic [N-1:0] Diff;
    logic         Bout;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B, Bin,
        input  Diff, Bout, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output Diff, Bout, busy, done
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B - Bin, one bit per cycle, LSB first.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned N = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned      CW   = cnt_width(N);
    localparam logic [CW-1:0]    LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          br_q, br_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          fs_d;
    logic          fs_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state, datapath and registered-output logic.
    // The result/done registers are loaded from the DONE state itself, so the
    // done pulse lands on the cycle the next operation (if any) is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    diff_d = res_q;
                    bout_d = br_q;
                    done_d = 1'b1;
                end
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.Bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                res_d = {fs_d, res_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at N=4.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    serial_subtractor_if #(.N(4)) bus ();

    serial_subtractor #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then count edges until done (bounded).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          output int lat, output logic [3:0] d, output logic bo);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d  = bus.Diff;
        bo = bus.Bout;
    endtask

    initial begin
        int         lat;
        int         ndone;
        int         t;
        logic [3:0] d;
        logic       bo;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_diff", bus.Diff, 4'b0000);
        check("rst_bout", bus.Bout, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;

        run_op(4'b0000, 4'b0000, 1'b0, lat, d, bo);
        check("zero_lat", lat, 5);
        check("zero_diff", d, 4'b0000);
        check("zero_bout", bo, 1'b0);

        run_op(4'b1111, 4'b0000, 1'b1, lat, d, bo);
        check("f_0_1_lat", lat, 5);
        check("f_0_1_diff", d, 4'b1110);
        check("f_0_1_bout", bo, 1'b0);
        @(negedge clk);
        check("done_one_cycle", bus.done, 1'b0);
        check("diff_hold", bus.Diff, 4'b1110);
        check("idle_busy", bus.busy, 1'b0);

        run_op(4'b0111, 4'b1111, 1'b1, lat, d, bo);
        check("7_f_1_diff", d, 4'b0111);
        check("7_f_1_bout", bo, 1'b1);

        run_op(4'b0000, 4'b0001, 1'b0, lat, d, bo);
        check("0_1_0_diff", d, 4'b1111);
        check("0_1_0_bout", bo, 1'b1);

        run_op(4'b0101, 4'b0101, 1'b1, lat, d, bo);
        check("5_5_1_diff", d, 4'b1111);
        check("5_5_1_bout", bo, 1'b1);

        run_op(4'b1000, 4'b0111, 1'b0, lat, d, bo);
        check("8_7_0_diff", d, 4'b0001);
        check("8_7_0_bout", bo, 1'b0);

        // Second start two cycles into SHIFT must be ignored.
        @(negedge clk);
        bus.A = 4'b1010; bus.B = 4'b0011; bus.Bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_shift", bus.busy, 1'b1);
        @(negedge clk);
        bus.A = 4'b1111; bus.B = 4'b0000; bus.Bin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                d  = bus.Diff;
                bo = bus.Bout;
            end
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_diff", d, 4'b0111);
        check("ignore_bout", bo, 1'b0);

        // Reset during SHIFT aborts without a done pulse.
        @(negedge clk);
        bus.A = 4'b1111; bus.B = 4'b0001; bus.Bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_diff", bus.Diff, 4'b0000);
        check("abort_bout", bus.Bout, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst_n = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; bus.start = 1'b0;
        check("rst_prio_busy", bus.busy, 1'b0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_ndone", ndone, 0);

        run_op(4'b1111, 4'b0001, 1'b0, lat, d, bo);
        check("post_rst_lat", lat, 5);
        check("post_rst_diff", d, 4'b1110);
        check("post_rst_bout", bo, 1'b0);

        // start held high through DONE: back-to-back operations.
        @(negedge clk);
        bus.A = 4'b1111; bus.B = 4'b0000; bus.Bin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.A = 4'b0111; bus.B = 4'b1111; bus.Bin = 1'b1;
        t = 0;
        while (!bus.done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("b2b_lat1", t, 5);
        check("b2b_diff1", bus.Diff, 4'b1110);
        check("b2b_bout1", bus.Bout, 1'b0);
        check("b2b_busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.done && t < 20);
        check("b2b_gap", t, 5);
        check("b2b_diff2", bus.Diff, 4'b0111);
        check("b2b_bout2", bus.Bout, 1'b1);
        @(negedge clk);
        check("b2b_end_done", bus.done, 1'b0);
        check("b2b_end_busy", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
